// File: rtl/booth_pkg.sv
// Shared encodings for the Booth multiplier family: controller states and
// radix-4 recode operations.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    ADD1 = 3'd1,
    ADD2 = 3'd2,
    SUB1 = 3'd3,
    SUB2 = 3'd4
  } op_t;

endpackage

// File: rtl/booth_radix4_recode.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window {b[i+1], b[i], b[i-1]}
// to the partial-product operation applied to the multiplicand.
module booth_radix4_recode
  import booth_pkg::*;
(
  input  logic [2:0] i_window,
  output op_t        o_op
);

  always_comb begin
    o_op = ZERO;
    case (i_window)
      3'b001, 3'b010: o_op = ADD1;
      3'b011:         o_op = ADD2;
      3'b100:         o_op = SUB2;
      3'b101, 3'b110: o_op = SUB1;
      default:        o_op = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_mult_n.sv
// Sequential radix-4 Booth multiplier, signed or unsigned, two product bits per cycle.
// start is accepted whenever busy=0; resultReady pulses once per accepted request.
module booth_mult_n
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             dataReset,
  input  logic             start,
  input  logic             signedMode,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             resultReady,
  output logic [WIDTH-1:0] resultLo,
  output logic [WIDTH-1:0] resultHi,
  output logic             overflow,
  output state_t           o_dbg_state
);

  localparam int EW = WIDTH + 2;
  localparam int AW = 2 * EW + 1;
  localparam int K  = WIDTH / 2 + 1;
  localparam int CW = $clog2(K + 1);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  state_t             r_state, w_state_next;
  logic [CW-1:0]      r_count;
  logic [AW-1:0]      r_acc;
  logic [EW-1:0]      r_mcand;
  logic               r_signed;
  logic [WIDTH-1:0]   r_lo, r_hi;
  logic               r_ovf;

  op_t                w_op;
  logic               w_accept, w_last, w_ovf;
  logic [EW-1:0]      w_a_ext, w_b_ext;
  logic [EW:0]        w_mcand_x, w_addend, w_sum;
  logic [AW-1:0]      w_acc_shift;
  logic [2*WIDTH-1:0] w_product;

  booth_radix4_recode u_recode (
    .i_window (r_acc[2:0]),
    .o_op     (w_op)
  );

  assign w_a_ext   = {{2{signedMode & multiplicand[WIDTH-1]}}, multiplicand};
  assign w_b_ext   = {{2{signedMode & multiplier[WIDTH-1]}}, multiplier};
  assign w_mcand_x = {r_mcand[EW-1], r_mcand};

  always_comb begin
    w_addend = '0;
    case (w_op)
      ADD1:    w_addend = w_mcand_x;
      ADD2:    w_addend = {r_mcand, 1'b0};
      SUB1:    w_addend = -w_mcand_x;
      SUB2:    w_addend = -{r_mcand, 1'b0};
      default: w_addend = '0;
    endcase
  end

  // One extra bit on the upper add keeps |upper| + 2|A| from wrapping before the shift.
  assign w_sum       = {r_acc[AW-1], r_acc[AW-1:EW+1]} + w_addend;
  assign w_acc_shift = {w_sum[EW], w_sum, r_acc[EW:2]};
  assign w_product   = w_acc_shift[2*WIDTH:1];

  always_comb begin
    w_ovf = 1'b0;
    if (r_signed)
      w_ovf = (w_product[2*WIDTH-1:WIDTH] != {WIDTH{w_product[WIDTH-1]}});
    else
      w_ovf = (w_product[2*WIDTH-1:WIDTH] != '0);
  end

  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_state == RUN) && (r_count == LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge dataReset) begin
    if (dataReset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_signed <= 1'b0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_mcand  <= w_a_ext;
        r_signed <= signedMode;
        r_acc    <= {{EW{1'b0}}, w_b_ext, 1'b0};
        r_count  <= '0;
      end else if (r_state == RUN) begin
        r_acc   <= w_acc_shift;
        r_count <= r_count + CW'(1);
        if (w_last) begin
          r_lo  <= w_product[WIDTH-1:0];
          r_hi  <= w_product[2*WIDTH-1:WIDTH];
          r_ovf <= w_ovf;
        end
      end
    end
  end

  assign busy        = (r_state == RUN);
  assign resultReady = (r_state == DONE);
  assign resultLo    = r_lo;
  assign resultHi    = r_hi;
  assign overflow    = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_booth_mult_n.sv
// Bench for booth_mult_n at WIDTH=32 and WIDTH=8: arithmetic reference model
// compared every cycle, plus hand-computed literal vectors.
module tb_booth_mult_n;
  import booth_pkg::*;

  logic        clock = 1'b0;
  logic        dataReset;
  logic        start32, sm32, start8, sm8;
  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;
  logic        busy32, rdy32, ovf32, busy8, rdy8, ovf8;
  logic [31:0] lo32, hi32;
  logic [7:0]  lo8, hi8;
  state_t      dbg32, dbg8;

  int checks = 0;
  int errors = 0;

  // Reference model state: index 0 is the 32-bit unit, index 1 the 8-bit unit.
  int          m_cnt [2];
  logic        m_rdy [2];
  logic [64:0] m_res [2];
  logic [64:0] m_pend[2];

  booth_mult_n #(.WIDTH(32)) dut32 (
    .clock(clock), .dataReset(dataReset), .start(start32), .signedMode(sm32),
    .multiplicand(a32), .multiplier(b32), .busy(busy32), .resultReady(rdy32),
    .resultLo(lo32), .resultHi(hi32), .overflow(ovf32), .o_dbg_state(dbg32)
  );

  booth_mult_n #(.WIDTH(8)) dut8 (
    .clock(clock), .dataReset(dataReset), .start(start8), .signedMode(sm8),
    .multiplicand(a8), .multiplier(b8), .busy(busy8), .resultReady(rdy8),
    .resultLo(lo8), .resultHi(hi8), .overflow(ovf8), .o_dbg_state(dbg8)
  );

  // clock / reset block
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Exact product from plain arithmetic: returns {overflow, hi[31:0], lo[31:0]}.
  function automatic logic [64:0] model_mul(input int w, input logic sm,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask, ea, eb, p, lo, hi;
    longint      sp, lim;
    logic        ovf;
    mask = (64'd1 << w) - 64'd1;
    ea = {32'd0, a} & mask;
    eb = {32'd0, b} & mask;
    if (sm && ea[w-1]) ea = ea | ~mask;
    if (sm && eb[w-1]) eb = eb | ~mask;
    p  = ea * eb;
    lo = p & mask;
    hi = (p >> w) & mask;
    if (sm) begin
      sp  = $signed(p);
      lim = longint'(1) <<< (w - 1);
      ovf = (sp < -lim) || (sp > lim - 1);
    end else begin
      ovf = ((p >> w) != 64'd0);
    end
    return {ovf, hi[31:0], lo[31:0]};
  endfunction

  always @(posedge clock or posedge dataReset) begin
    if (dataReset) begin
      for (int d = 0; d < 2; d++) begin
        m_cnt[d] <= 0;
        m_rdy[d] <= 1'b0;
        m_res[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_cnt[d] != 0) begin
          m_cnt[d] <= m_cnt[d] - 1;
          m_rdy[d] <= (m_cnt[d] == 1);
          if (m_cnt[d] == 1) m_res[d] <= m_pend[d];
        end else begin
          m_rdy[d] <= 1'b0;
          if (d == 0 && start32) begin
            m_pend[d] <= model_mul(32, sm32, a32, b32);
            m_cnt[d]  <= 17;
          end else if (d == 1 && start8) begin
            m_pend[d] <= model_mul(8, sm8, {24'd0, a8}, {24'd0, b8});
            m_cnt[d]  <= 5;
          end
        end
      end
    end
  end

  // scoreboard compare: every output of both units, every cycle
  initial begin
    forever begin
      @(negedge clock);
      check("busy32", {63'd0, busy32}, {63'd0, m_cnt[0] != 0});
      check("dbg32_run", {63'd0, dbg32 == RUN}, {63'd0, m_cnt[0] != 0});
      check("ready32", {63'd0, rdy32}, {63'd0, m_rdy[0]});
      check("lo32", {32'd0, lo32}, {32'd0, m_res[0][31:0]});
      check("hi32", {32'd0, hi32}, {32'd0, m_res[0][63:32]});
      check("ovf32", {63'd0, ovf32}, {63'd0, m_res[0][64]});
      check("busy8", {63'd0, busy8}, {63'd0, m_cnt[1] != 0});
      check("dbg8_run", {63'd0, dbg8 == RUN}, {63'd0, m_cnt[1] != 0});
      check("ready8", {63'd0, rdy8}, {63'd0, m_rdy[1]});
      check("lo8", {56'd0, lo8}, {32'd0, m_res[1][31:0]});
      check("hi8", {56'd0, hi8}, {32'd0, m_res[1][63:32]});
      check("ovf8", {63'd0, ovf8}, {63'd0, m_res[1][64]});
    end
  end

  // driver tasks
  task automatic start_op(input int d, input logic sm, input logic [31:0] a, input logic [31:0] b);
    if (d == 0) begin
      sm32 = sm; a32 = a; b32 = b; start32 = 1'b1;
    end else begin
      sm8 = sm; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
    end
    @(posedge clock);
    #2;
    start32 = 1'b0;
    start8  = 1'b0;
  endtask

  task automatic wait_ready(input int d, input int base, output int cyc);
    logic r;
    cyc = base;
    r   = 1'b0;
    while (!r && cyc < base + 60) begin
      @(negedge clock);
      cyc++;
      r = (d == 0) ? rdy32 : rdy8;
    end
    if (!r) begin
      checks++;
      errors++;
      $display("FAIL timeout_ready unit=%0d actual=none required=pulse", d);
    end
  endtask

  task automatic expect_op(input string name, input int d, input logic sm,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] elo, input logic [31:0] ehi,
                           input logic eovf, input int ecyc);
    int cyc;
    start_op(d, sm, a, b);
    wait_ready(d, 0, cyc);
    check({name, "_cycle"}, 64'(cyc), 64'(ecyc));
    check({name, "_lo"}, (d == 0) ? {32'd0, lo32} : {56'd0, lo8}, {32'd0, elo});
    check({name, "_hi"}, (d == 0) ? {32'd0, hi32} : {56'd0, hi8}, {32'd0, ehi});
    check({name, "_ovf"}, (d == 0) ? {63'd0, ovf32} : {63'd0, ovf8}, {63'd0, eovf});
  endtask

  initial begin
    int cyc;
    dataReset = 1'b1;
    start32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
    start8  = 1'b0; sm8  = 1'b0; a8  = '0; b8  = '0;
    repeat (3) @(posedge clock);
    #2;
    check("rst_busy", {63'd0, busy32}, 64'd0);
    check("rst_ready", {63'd0, rdy32}, 64'd0);
    check("rst_outs", {ovf32, hi32, lo32}, 64'd0);
    dataReset = 1'b0;
    @(posedge clock);
    #2;

    expect_op("s7xm3", 0, 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 18);
    expect_op("min_sq", 0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h4000_0000, 1'b1, 18);
    expect_op("umax_sq", 0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 1'b1, 18);
    expect_op("smax_sq", 0, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h1, 32'h3FFF_FFFF, 1'b1, 18);
    expect_op("m1x1", 0, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 18);
    expect_op("minx1", 0, 1'b1, 32'h8000_0000, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 18);
    expect_op("u2p32", 0, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h1, 1'b1, 18);
    expect_op("ufit", 0, 1'b0, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 32'h0, 1'b0, 18);
    expect_op("zero", 0, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, 18);

    // a second start while busy must be ignored
    start_op(0, 1'b1, 32'd5, 32'd6);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2;
    sm32 = 1'b1; a32 = 32'd9; b32 = 32'd9; start32 = 1'b1;
    @(posedge clock);
    #2;
    start32 = 1'b0;
    wait_ready(0, 4, cyc);
    check("ign_cycle", 64'(cyc), 64'd18);
    check("ign_lo", {32'd0, lo32}, 64'd30);
    check("ign_hi", {32'd0, hi32}, 64'd0);

    // reset mid-run, start held during reset accepted only after release
    @(posedge clock);
    #2;
    start_op(0, 1'b0, 32'd100, 32'd200);
    repeat (7) @(posedge clock);
    #2;
    dataReset = 1'b1;
    #1;
    check("mid_rst_busy", {63'd0, busy32}, 64'd0);
    check("mid_rst_ready", {63'd0, rdy32}, 64'd0);
    check("mid_rst_outs", {ovf32, hi32, lo32}, 64'd0);
    sm32 = 1'b1; a32 = 32'd12; b32 = 32'hFFFF_FFF4; start32 = 1'b1;
    @(posedge clock);
    #2;
    dataReset = 1'b0;
    #1;
    check("rst_held_start", {63'd0, busy32}, 64'd0);
    @(posedge clock);
    #2;
    start32 = 1'b0;
    wait_ready(0, 0, cyc);
    check("post_rst_cycle", 64'(cyc), 64'd18);
    check("post_rst_lo", {32'd0, lo32}, {32'd0, 32'hFFFF_FF70});
    check("post_rst_hi", {32'd0, hi32}, {32'd0, 32'hFFFF_FFFF});
    check("post_rst_ovf", {63'd0, ovf32}, 64'd0);

    expect_op("w8_min_m1", 1, 1'b1, 32'h80, 32'hFF, 32'h80, 32'h00, 1'b1, 6);
    expect_op("w8_umax", 1, 1'b0, 32'hFF, 32'hFF, 32'h01, 32'hFE, 1'b1, 6);
    expect_op("w8_max_min", 1, 1'b1, 32'h7F, 32'h80, 32'h80, 32'hC0, 1'b1, 6);
    expect_op("w8_3xm2", 1, 1'b1, 32'h03, 32'hFE, 32'hFA, 32'hFF, 1'b0, 6);
    expect_op("w8_min_sq", 1, 1'b1, 32'h80, 32'h80, 32'h00, 32'h40, 1'b1, 6);

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mult_n.md
BOOTH_MULT_N -- requirements
Module: booth_mult_n

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal values are even and >= 4.
REQ-002 SHALL have port clock  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port dataReset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a multiply, sampled on the clock edge.
REQ-005 SHALL have port signedMode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port multiplicand  input  WIDTH  operand A, sampled with start.
REQ-007 SHALL have port multiplier  input  WIDTH  operand B, sampled with start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port resultReady  output  1  single-cycle pulse marking a valid result.
REQ-010 SHALL have port resultLo  output  WIDTH  low half of the 2*WIDTH product.
REQ-011 SHALL have port resultHi  output  WIDTH  high half of the 2*WIDTH product.
REQ-012 SHALL have port overflow  output  1  product does not fit in WIDTH bits for the sampled mode.

Function
REQ-013 SHALL implement radix-4 Booth multiplication, with operands extended to WIDTH+2 bits: sign-extended when signedMode=1, zero-extended when signedMode=0.
REQ-014 SHALL run iteration count K = WIDTH/2 + 1, tracked by an internal counter of ceil(log2(K+1)) bits; no external count input.
REQ-015 SHALL use FSM states IDLE, RUN, DONE.
REQ-016 SHALL, in IDLE or DONE, accept start=1 at an edge: capture operands and mode, clear the accumulator, zero the counter, enter RUN.
REQ-017 SHALL, in RUN, per cycle: recode the 3 LSBs of the multiplier window to {0, +A, +2A, -A, -2A}, add to the upper accumulator, arithmetic-shift right 2, increment counter.
REQ-018 SHALL leave RUN for DONE on the edge that completes iteration K.
REQ-019 SHALL drive resultReady=1 for exactly the one cycle spent in DONE; DONE then returns to IDLE unless start=1.
REQ-020 SHALL produce latency: resultReady high in the (K+1)th cycle after the start-accept edge (WIDTH=32: 18th cycle).
REQ-021 SHALL hold busy=1 in RUN only; busy=0 in IDLE and DONE.
REQ-022 SHALL register resultLo, resultHi and overflow on entry to DONE and hold them stable until the next DONE entry or reset.
REQ-023 SHALL ignore start while busy=1: no restart, no operand change.
REQ-024 SHALL compute overflow in signed mode as 1 iff resultHi differs from WIDTH copies of resultLo[WIDTH-1].
REQ-025 SHALL compute overflow in unsigned mode as 1 iff resultHi != 0.
REQ-026 SHALL give the exact 2*WIDTH product, with no saturation, for all operands including most-negative x most-negative.
REQ-027 SHALL drive no X on any output when the inputs are known.

Reset
REQ-028 SHALL, on dataReset=1 at any time (including mid-RUN), immediately enter IDLE and clear the counter, accumulator, busy, resultReady, resultLo, resultHi and overflow to 0.
REQ-029 SHALL ignore start while dataReset=1; the first accept occurs on the first edge after deassertion.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE/RUN/DONE) and the recode op encoding (ZERO, ADD1, ADD2, SUB1, SUB2) in shared package booth_pkg.
REQ-031 SHALL contain one sub-module, booth_radix4_recode: combinational 3-bit window -> op, reused by future multiplier variants.
REQ-032 SHALL keep the accumulator width at 2*(WIDTH+2)+1 bits, including the appended Booth guard bit.

Verification
REQ-033 SHALL cover: WIDTH=32, signed, 7 x -3 -> resultLo=0xFFFFFFEB, resultHi=0xFFFFFFFF, overflow=0, resultReady on cycle 18.
REQ-034 SHALL cover: WIDTH=32, signed, 0x80000000 x 0x80000000 -> resultHi=0x40000000, resultLo=0, overflow=1.
REQ-035 SHALL cover: WIDTH=32, unsigned, 0xFFFFFFFF x 0xFFFFFFFF -> resultHi=0xFFFFFFFE, resultLo=0x00000001, overflow=1.
REQ-036 SHALL cover: start with 5 x 6, then start with 9 x 9 at cycle 4 -> second request ignored; result 30 delivered on cycle 18.
REQ-037 SHALL cover: dataReset pulse at cycle 8 of a run -> all outputs 0 and busy=0 at once; no resultReady; a new start afterwards completes normally.
REQ-038 SHALL cover: WIDTH=8, signed, 0x80 x 0xFF -> {resultHi,resultLo}=0x0080, overflow=1, resultReady on cycle 6.
